uart_tx_ctrl: RTL and testbench

- Frame sequencer for the UART transmit path.
- Consumes the oversampled tick from baud_generator and gates that generator on and off via an enable output.
- Serialises one parallel word per valid/ready handshake into start, data (LSB first), optional parity and stop bits.
- Sits between the host-side byte source and the tx pin.

---
 rtl/uart_tx_ctrl.sv | 130 +++++++++++++
 tb/tb_uart_tx_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: serialises one word per valid/ready handshake into
// start, LSB-first data, optional parity and stop bits, pacing bits from the baud tick.
module uart_tx_ctrl #(
  parameter int DATA_BITS         = 8,
  parameter int OVERSAMPLING_RATE = 8,
  parameter bit PARITY_EN         = 1'b0,
  parameter bit PARITY_ODD        = 1'b0,
  parameter int STOP_BITS         = 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 tick_in,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  output logic                 tx_out,
  output logic                 baud_en_out,
  output logic                 busy_out,
  output logic                 done_out
);

  localparam int TW = (OVERSAMPLING_RATE > 2) ? $clog2(OVERSAMPLING_RATE) : 1;
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLING_RATE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic [TW-1:0]         tick_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_BITS-1:0]  shift;
  logic                  parity;
  logic                  bit_end;

  assign bit_end = tick_in && (tick_cnt == TICK_LAST);

  // tx_out is loaded with the level of the next bit on the edge that ends the
  // current one, so the line changes exactly one cycle after the last tick.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      parity      <= 1'b0;
      tx_out      <= 1'b1;
      ready_out   <= 1'b0;
      baud_en_out <= 1'b0;
      busy_out    <= 1'b0;
      done_out    <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in && ready_out) begin
            shift       <= data_in;
            parity      <= 1'b0;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            state       <= START;
            tx_out      <= 1'b0;
            busy_out    <= 1'b1;
            baud_en_out <= 1'b1;
            ready_out   <= 1'b0;
          end else begin
            tx_out      <= 1'b1;
            busy_out    <= 1'b0;
            baud_en_out <= 1'b0;
            ready_out   <= 1'b1;
          end
        end
        default: begin
          if (tick_in) begin
            tick_cnt <= bit_end ? '0 : tick_cnt + TW'(1);
            if (bit_end) begin
              case (state)
                START: begin
                  state   <= DATA;
                  bit_cnt <= '0;
                  tx_out  <= shift[0];
                end
                DATA: begin
                  parity <= parity ^ shift[0];
                  shift  <= shift >> 1;
                  if (bit_cnt == DATA_LAST) begin
                    bit_cnt <= '0;
                    if (PARITY_EN) begin
                      state  <= PARITY;
                      tx_out <= parity ^ shift[0] ^ PARITY_ODD;
                    end else begin
                      state  <= STOP;
                      tx_out <= 1'b1;
                    end
                  end else begin
                    bit_cnt <= bit_cnt + BW'(1);
                    tx_out  <= shift[1];
                  end
                end
                PARITY: begin
                  state   <= STOP;
                  bit_cnt <= '0;
                  tx_out  <= 1'b1;
                end
                STOP: begin
                  tx_out <= 1'b1;
                  if (bit_cnt == STOP_LAST) begin
                    // Ready rises with done so a waiting source can hand over back-to-back.
                    state       <= IDLE;
                    bit_cnt     <= '0;
                    busy_out    <= 1'b0;
                    baud_en_out <= 1'b0;
                    ready_out   <= 1'b1;
                    done_out    <= 1'b1;
                  end else begin
                    bit_cnt <= bit_cnt + BW'(1);
                  end
                end
                default: state <= IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: four parameter variants share tick/data/reset, each with its
// own valid; a tick-counting frame model is compared every cycle plus literal expectations.
module tb_uart_tx_ctrl;
  localparam int N   = 4;
  localparam int OSR = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick_run = 1'b0;
  logic tick;
  logic [8:0] data = '0;
  logic [N-1:0] valid = '0;
  logic [N-1:0] tx, ready, busy, baud, done;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign tick = tick_run && (cyc[1:0] == 2'd0);

  // 0: defaults, 1: even parity, 2: odd parity, 3: 7 data bits + 2 stop bits
  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int DB = (g == 3) ? 7 : 8;
    uart_tx_ctrl #(
      .DATA_BITS(DB),
      .OVERSAMPLING_RATE(OSR),
      .PARITY_EN(g == 1 || g == 2),
      .PARITY_ODD(g == 2),
      .STOP_BITS((g == 3) ? 2 : 1)
    ) u_dut (
      .clk_in(clk),
      .rst_in(rst),
      .tick_in(tick),
      .data_in(data[DB-1:0]),
      .valid_in(valid[g]),
      .ready_out(ready[g]),
      .tx_out(tx[g]),
      .baud_en_out(baud[g]),
      .busy_out(busy[g]),
      .done_out(done[g])
    );
  end

  function automatic int cfg_db(int k); return (k == 3) ? 7 : 8; endfunction
  function automatic int cfg_pe(int k); return (k == 1 || k == 2) ? 1 : 0; endfunction
  function automatic int cfg_po(int k); return (k == 2) ? 1 : 0; endfunction
  function automatic int cfg_sb(int k); return (k == 3) ? 2 : 1; endfunction

  // Bit i of the result is the i-th level on the line; unused tail stays high.
  function automatic logic [15:0] frame_bits(int k, logic [8:0] d);
    logic [15:0] b;
    logic p;
    b = '1;
    b[0] = 1'b0;
    p = 1'b0;
    for (int i = 0; i < cfg_db(k); i++) begin
      b[1+i] = d[i];
      p = p ^ d[i];
    end
    if (cfg_pe(k) != 0) b[1+cfg_db(k)] = p ^ (cfg_po(k) != 0);
    return b;
  endfunction

  function automatic int frame_ticks(int k);
    return OSR * (1 + cfg_db(k) + cfg_pe(k) + cfg_sb(k));
  endfunction

  // Model: a frame is the bit list plus the number of ticks seen since the handshake.
  logic [15:0]  m_bits [N];
  int           m_ticks [N];
  int           m_len [N];
  logic [N-1:0] m_active = '0;
  logic [N-1:0] m_ready = '0;
  logic [N-1:0] m_done = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        m_active[k] <= 1'b0;
        m_ready[k]  <= 1'b0;
        m_done[k]   <= 1'b0;
        m_ticks[k]  <= 0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        m_done[k] <= 1'b0;
        if (!m_active[k]) begin
          if (valid[k] && m_ready[k]) begin
            m_bits[k]   <= frame_bits(k, data);
            m_len[k]    <= frame_ticks(k);
            m_ticks[k]  <= 0;
            m_active[k] <= 1'b1;
            m_ready[k]  <= 1'b0;
          end else begin
            m_ready[k] <= 1'b1;
          end
        end else if (tick) begin
          m_ticks[k] <= m_ticks[k] + 1;
          if (m_ticks[k] + 1 == m_len[k]) begin
            m_active[k] <= 1'b0;
            m_done[k]   <= 1'b1;
            m_ready[k]  <= 1'b1;
          end
        end
      end
    end
  end

  function automatic logic exp_tx(int k);
    return m_active[k] ? m_bits[k][m_ticks[k] / OSR] : 1'b1;
  endfunction

  task automatic check(input string name, input int k, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got %b expected %b", name, k, $time, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < N; k++) begin
        check("tx", k, tx[k], exp_tx(k));
        check("busy", k, busy[k], m_active[k]);
        check("baud_en", k, baud[k], m_active[k]);
        check("ready", k, ready[k], m_ready[k]);
        check("done", k, done[k], m_done[k]);
      end
    end
  end

  logic tx_s  [0:1023];
  logic rdy_s [0:1023];
  int done_idx;
  int done_cnt;

  // Present a word so that the handshake edge coincides with a tick edge.
  task automatic send(input int k, input logic [8:0] d);
    @(negedge clk);
    while (cyc[1:0] != 2'd0) @(negedge clk);
    data = d;
    valid[k] = 1'b1;
  endtask

  // Sample j is taken at the falling edge following handshake edge + j cycles.
  task automatic capture(input int k, input int n, input int drop_at,
                         input logic [8:0] d2, input int freeze_at);
    done_idx = -1;
    done_cnt = 0;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      tx_s[j]  = tx[k];
      rdy_s[j] = ready[k];
      if (done[k]) begin
        done_cnt++;
        if (done_idx < 0) done_idx = j;
      end
      if (j == 0) data = d2;
      if (j == drop_at) valid[k] = 1'b0;
      if (j == freeze_at) tick_run = 1'b0;
      if (freeze_at >= 0 && j == freeze_at + 100) tick_run = 1'b1;
    end
  endtask

  initial begin
    logic [9:0] e;
    int dseen;
    #2 rst = 1'b1;
    #2;
    for (int k = 0; k < N; k++) begin
      check("rst_tx", k, tx[k], 1'b1);
      check("rst_ready", k, ready[k], 1'b0);
      check("rst_busy", k, busy[k], 1'b0);
      check("rst_baud", k, baud[k], 1'b0);
      check("rst_done", k, done[k], 1'b0);
    end
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 check("ready_after_rst", 0, ready[0], 1'b1);
    tick_run = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_tick_tx", 0, tx[0], 1'b1);

    // 0xA5 on defaults, data changed right after the handshake
    send(0, 9'h0A5);
    capture(0, 340, 0, 9'h05A, -1);
    e = 10'b1101001010;
    for (int i = 0; i < 10; i++) check("a5_bit", i, tx_s[i*32+16], e[i]);
    check("a5_start_first", 0, tx_s[0], 1'b0);
    check("a5_start_last", 0, tx_s[31], 1'b0);
    check("a5_bit0_first", 0, tx_s[32], 1'b1);
    check_int("a5_done_idx", done_idx, 320);
    check_int("a5_done_cnt", done_cnt, 1);

    // parity variants
    send(1, 9'h0A5);
    capture(1, 360, 0, 9'h0A5, -1);
    check("even_parity", 1, tx_s[304], 1'b0);
    check("even_stop", 1, tx_s[336], 1'b1);
    check_int("even_done_idx", done_idx, 352);
    send(2, 9'h0A5);
    capture(2, 360, 0, 9'h0A5, -1);
    check("odd_parity", 2, tx_s[304], 1'b1);
    check_int("odd_done_idx", done_idx, 352);

    // back-to-back frames with valid held
    send(0, 9'h03C);
    capture(0, 660, 321, 9'h0C3, -1);
    check("b2b_stop", 0, tx_s[319], 1'b1);
    check("b2b_ready_busy", 0, rdy_s[319], 1'b0);
    check("b2b_ready_done", 0, rdy_s[320], 1'b1);
    check_int("b2b_done1_idx", done_idx, 320);
    check("b2b_start2", 0, tx_s[321], 1'b0);
    check("b2b_ready2", 0, rdy_s[321], 1'b0);
    check("b2b_f2_bit0", 0, tx_s[368], 1'b1);
    check("b2b_f2_bit2", 0, tx_s[432], 1'b0);
    check_int("b2b_done_cnt", done_cnt, 2);

    // asynchronous reset during data bit 3
    send(0, 9'h037);
    capture(0, 140, 0, 9'h037, -1);
    check("pre_rst_tx", 0, tx[0], 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_tx", 0, tx[0], 1'b1);
    check("async_rst_busy", 0, busy[0], 1'b0);
    check("async_rst_baud", 0, baud[0], 1'b0);
    check("async_rst_done", 0, done[0], 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dseen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done[0]) dseen++;
    end
    check_int("no_done_after_rst", dseen, 0);
    send(0, 9'h000);
    capture(0, 340, 0, 9'h000, -1);
    check("z_bit0", 0, tx_s[48], 1'b0);
    check("z_bit7", 0, tx_s[272], 1'b0);
    check("z_stop", 0, tx_s[304], 1'b1);
    check_int("z_done_idx", done_idx, 320);

    // tick stalled for 100 cycles inside data bit 3
    send(0, 9'h05A);
    capture(0, 440, 0, 9'h05A, 150);
    check("frz_hold_a", 0, tx_s[150], 1'b1);
    check("frz_hold_b", 0, tx_s[259], 1'b1);
    check("frz_bit5", 0, tx_s[308], 1'b0);
    check_int("frz_done_idx", done_idx, 420);

    // 7 data bits, 2 stop bits
    send(3, 9'h07F);
    capture(3, 340, 0, 9'h07F, -1);
    check("s2_start", 3, tx_s[16], 1'b0);
    check("s2_bit0", 3, tx_s[48], 1'b1);
    check("s2_stop1", 3, tx_s[272], 1'b1);
    check("s2_stop2", 3, tx_s[304], 1'b1);
    check_int("s2_done_idx", done_idx, 320);
    check_int("s2_done_cnt", done_cnt, 1);

    repeat (20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
